// File: rtl/video_pattern_tx.sv
// Raster test-pattern source: hs/vs/de timing, x/y coordinates and an 8-bit gray
// pixel, all registered and mutually aligned on the same clock.
module video_pattern_tx #(
  parameter int          H_ACTIVE  = 128,
  parameter int          H_FP      = 4,
  parameter int          H_SYNC    = 8,
  parameter int          H_BP      = 4,
  parameter int          V_ACTIVE  = 96,
  parameter int          V_FP      = 2,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 2,
  parameter int          CHK_SHIFT = 3,
  parameter logic [7:0]  FG_LEVEL  = 8'd200,
  parameter logic [7:0]  BG_LEVEL  = 8'd40,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic        video_clk,
  input  logic        rst_n,
  input  logic        iEn,
  input  logic [2:0]  iMode,
  input  logic [7:0]  iConst,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic [7:0]  oGray,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
  localparam logic [11:0] H_HALF     = 12'(H_ACTIVE / 2);
  localparam logic [11:0] H_SYNC_ON  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_OFF = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_ON  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_OFF = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST     = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [11:0] hcnt, vcnt, hcnt_nxt, vcnt_nxt;
  logic [2:0]  mode, mode_nxt, pix_mode;
  logic [7:0]  lfsr, lfsr_nxt, pix_lfsr;
  logic [15:0] frame_cnt_nxt;
  logic        start, park;
  logic        hs_nxt, vs_nxt, de_nxt;
  logic [11:0] x_nxt, y_nxt, chk_x, chk_y;
  logic [7:0]  gray_nxt;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Counters hold the position currently on the outputs; the *_nxt values are
  // the position (and its decoded pixel) that the next edge will present.
  always_comb begin
    state_nxt     = state;
    hcnt_nxt      = hcnt;
    vcnt_nxt      = vcnt;
    frame_cnt_nxt = frame_cnt;
    start         = 1'b0;
    park          = 1'b0;
    case (state)
      IDLE: begin
        hcnt_nxt = '0;
        vcnt_nxt = '0;
        if (iEn) begin
          state_nxt = RUN;
          start     = 1'b1;
        end else begin
          park = 1'b1;
        end
      end
      RUN: begin
        if (hcnt == H_LAST) begin
          hcnt_nxt = '0;
          if (vcnt == V_LAST) begin
            vcnt_nxt      = '0;
            frame_cnt_nxt = frame_cnt + 16'd1;
            if (iEn) begin
              start = 1'b1;
            end else begin
              state_nxt = IDLE;
              park      = 1'b1;
            end
          end else begin
            vcnt_nxt = vcnt + 12'd1;
          end
        end else begin
          hcnt_nxt = hcnt + 12'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        park      = 1'b1;
      end
    endcase
  end

  // Pixel (0,0) of a frame already uses the newly sampled mode and reloaded seed.
  always_comb begin
    pix_mode = start ? iMode : mode;
    pix_lfsr = start ? LFSR_SEED : lfsr;
    mode_nxt = pix_mode;
    de_nxt   = !park && (hcnt_nxt < H_ACT) && (vcnt_nxt < V_ACT);
    hs_nxt   = !park && (hcnt_nxt >= H_SYNC_ON) && (hcnt_nxt < H_SYNC_OFF);
    vs_nxt   = !park && (vcnt_nxt >= V_SYNC_ON) && (vcnt_nxt < V_SYNC_OFF);
    x_nxt    = de_nxt ? hcnt_nxt : '0;
    y_nxt    = de_nxt ? vcnt_nxt : '0;
    chk_x    = hcnt_nxt >> CHK_SHIFT;
    chk_y    = vcnt_nxt >> CHK_SHIFT;
    lfsr_nxt = de_nxt ? lfsr_step(pix_lfsr) : pix_lfsr;
    gray_nxt = '0;
    if (de_nxt) begin
      case (pix_mode)
        3'd0:    gray_nxt = hcnt_nxt[7:0];
        3'd1:    gray_nxt = vcnt_nxt[7:0];
        3'd2:    gray_nxt = (chk_x[0] ^ chk_y[0]) ? 8'hFF : 8'h00;
        3'd3:    gray_nxt = pix_lfsr;
        3'd4:    gray_nxt = (hcnt_nxt < H_HALF) ? FG_LEVEL : BG_LEVEL;
        default: gray_nxt = iConst;
      endcase
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt        <= '0;
      vcnt        <= '0;
      mode        <= '0;
      lfsr        <= LFSR_SEED;
      frame_cnt   <= '0;
      hs          <= 1'b0;
      vs          <= 1'b0;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      oGray       <= '0;
      frame_start <= 1'b0;
    end else begin
      hcnt        <= hcnt_nxt;
      vcnt        <= vcnt_nxt;
      mode        <= mode_nxt;
      lfsr        <= lfsr_nxt;
      frame_cnt   <= frame_cnt_nxt;
      hs          <= hs_nxt;
      vs          <= vs_nxt;
      de          <= de_nxt;
      x           <= x_nxt;
      y           <= y_nxt;
      oGray       <= gray_nxt;
      frame_start <= start;
    end
  end

endmodule

// File: tb/tb_video_pattern_tx.sv
// Directed bench for video_pattern_tx: frame timing, every pattern mode, frame-boundary
// control of iEn/iMode, and asynchronous reset.
module tb_video_pattern_tx;

  logic        video_clk = 1'b0;
  logic        rst_n;
  logic        iEn;
  logic [2:0]  iMode;
  logic [7:0]  iConst;
  logic        hs, vs, de, frame_start;
  logic [11:0] x, y;
  logic [7:0]  oGray;
  logic [15:0] frame_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_fc;
  logic [7:0]  lf;

  video_pattern_tx dut (
    .video_clk   (video_clk),
    .rst_n       (rst_n),
    .iEn         (iEn),
    .iMode       (iMode),
    .iConst      (iConst),
    .hs          (hs),
    .vs          (vs),
    .de          (de),
    .x           (x),
    .y           (y),
    .oGray       (oGray),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  always #5 video_clk = ~video_clk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_hs"}, 32'(hs), 32'd0);
    chk({tag, "_vs"}, 32'(vs), 32'd0);
    chk({tag, "_de"}, 32'(de), 32'd0);
    chk({tag, "_x"}, 32'(x), 32'd0);
    chk({tag, "_y"}, 32'(y), 32'd0);
    chk({tag, "_gray"}, 32'(oGray), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    chk({tag, "_fcnt"}, 32'(frame_cnt), 32'(exp_fc));
  endtask

  // Entered at the sample point where pixel (0,0) should be showing; walks n_clk
  // positions against a reference raster model.
  task automatic run(input string tag, input int n_clk, input logic [2:0] mode,
                     input int chg_line, input logic [2:0] chg_mode,
                     input int drop_line, input bit full);
    int h = 0;
    int v = 0;
    int b_t = 0, b_xy = 0, b_g = 0, b_fs = 0, b_fc = 0;
    int n_de = 0, n_hs = 0, n_vs = 0;
    logic e_de, e_hs, e_vs;
    logic [11:0] e_x, e_y;
    logic [7:0] e_g;
    for (int i = 0; i < n_clk; i++) begin
      e_de = (h < 128) && (v < 96);
      e_hs = (h >= 132) && (h < 140);
      e_vs = (v >= 98) && (v < 100);
      e_x  = e_de ? 12'(h) : 12'd0;
      e_y  = e_de ? 12'(v) : 12'd0;
      if (h == 0 && v == 0) lf = 8'hA5;
      e_g = 8'd0;
      if (e_de) begin
        case (mode)
          3'd0: e_g = 8'(h);
          3'd1: e_g = 8'(v);
          3'd2: e_g = (((h >> 3) ^ (v >> 3)) & 1) != 0 ? 8'd255 : 8'd0;
          3'd3: begin e_g = lf; lf = lfsr_step(lf); end
          3'd4: e_g = (h < 64) ? 8'd200 : 8'd40;
          default: e_g = iConst;
        endcase
      end
      if (de !== e_de || hs !== e_hs || vs !== e_vs) b_t++;
      if (x !== e_x || y !== e_y) b_xy++;
      if (oGray !== e_g) b_g++;
      if (frame_start !== (h == 0 && v == 0)) b_fs++;
      if (frame_cnt !== exp_fc) b_fc++;
      n_de += int'(de);
      n_hs += int'(hs);
      n_vs += int'(vs);
      iConst = 8'($urandom_range(0, 255));
      if (v == chg_line && h == 0) iMode = chg_mode;
      if (v == drop_line && h == 0) iEn = 1'b0;
      @(negedge video_clk);
      if (h == 143) begin
        h = 0;
        if (v == 101) begin
          v = 0;
          exp_fc++;
        end else begin
          v++;
        end
      end else begin
        h++;
      end
    end
    chk({tag, "_timing_bad"}, 32'(b_t), 32'd0);
    chk({tag, "_xy_bad"}, 32'(b_xy), 32'd0);
    chk({tag, "_gray_bad"}, 32'(b_g), 32'd0);
    chk({tag, "_fs_bad"}, 32'(b_fs), 32'd0);
    chk({tag, "_fcnt_bad"}, 32'(b_fc), 32'd0);
    if (full) begin
      chk({tag, "_de_clks"}, 32'(n_de), 32'd12288);
      chk({tag, "_hs_clks"}, 32'(n_hs), 32'd816);
      chk({tag, "_vs_clks"}, 32'(n_vs), 32'd288);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    iEn    = 1'b1;
    iMode  = 3'd0;
    iConst = 8'd0;
    exp_fc = 16'd0;
    lf     = 8'hA5;
    repeat (3) @(negedge video_clk);
    check_idle("reset");

    rst_n = 1'b1;
    @(negedge video_clk);
    chk("first_fs", 32'(frame_start), 32'd1);
    chk("first_de", 32'(de), 32'd1);
    chk("first_x", 32'(x), 32'd0);
    chk("first_gray", 32'(oGray), 32'd0);
    // Frame 1: horizontal ramp, iMode switched to 1 at line 40
    run("hramp", 14688, 3'd0, 40, 3'd1, -1, 1'b1);
    chk("f1_fcnt", 32'(frame_cnt), 32'd1);
    run("vramp", 14688, 3'd1, 50, 3'd3, -1, 1'b1);
    chk("noise_first", 32'(oGray), 32'hA5);
    run("noise1", 14688, 3'd3, -1, 3'd0, -1, 1'b1);
    chk("noise_repeat_first", 32'(oGray), 32'hA5);
    run("noise2", 14688, 3'd3, -1, 3'd0, 40, 1'b1);

    check_idle("after_drop");
    chk("drop_fcnt", 32'(frame_cnt), 32'd4);
    repeat (20) @(negedge video_clk);
    check_idle("idle_hold");

    iMode = 3'd4;
    iEn   = 1'b1;
    @(negedge video_clk);
    chk("reen_fs", 32'(frame_start), 32'd1);
    run("bimodal", 3 * 144 + 50, 3'd4, -1, 3'd0, -1, 1'b0);
    chk("pre_rst_de", 32'(de), 32'd1);
    #2 rst_n = 1'b0;
    #1 exp_fc = 16'd0;
    check_idle("async_rst1");

    @(negedge video_clk);
    iMode = 3'd2;
    rst_n = 1'b1;
    @(negedge video_clk);
    run("checker", 10 * 144, 3'd2, -1, 3'd0, -1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_idle("async_rst2");

    @(negedge video_clk);
    iMode  = 3'd5;
    iConst = 8'h3C;
    rst_n  = 1'b1;
    @(negedge video_clk);
    chk("const_first", 32'(oGray), 32'h3C);
    run("const", 2 * 144 + 20, 3'd5, -1, 3'd0, -1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_idle("async_rst3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
